mc_burst_agen: RTL

Burst address generator for the memory controller. It accepts one burst command (start word address, beat count, linear or wrap mode) and emits one word address per beat on a valid/ready handshake, flagging the last beat. It sits between the command/arbitration stage and the memory address path, and it does the per-beat address stepping and burst-boundary wrap. One address per cycle is sustained under continuous ready.

---
 rtl/mc_burst_agen_pkg.sv | 12 +
 rtl/mc_burst_agen_cnt.sv | 34 +++
 rtl/mc_burst_agen.sv | 96 +++++++++
 3 files changed

// File: rtl/mc_burst_agen_pkg.sv
// Shared types and default widths for the burst address generator.
package mc_burst_agen_pkg;

   localparam int MC_AG_AW = 32;
   localparam int MC_AG_LW = 4;

   typedef enum logic {
      MC_AG_IDLE  = 1'b0,
      MC_AG_BURST = 1'b1
   } ag_state_t;

endpackage

// File: rtl/mc_burst_agen_cnt.sv
// Remaining-beat counter: load/decrement with a registered zero flag so the
// last-beat indication never depends on a live compare.
module mc_burst_cnt #(
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld,
   input  logic [LW-1:0] ld_val,
   input  logic          dec,
   output logic [LW-1:0] cnt,
   output logic          zero
);

   logic [LW-1:0] cnt_reg;
   logic          zero_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg  <= '0;
         zero_reg <= 1'b0;
      end else if (ld) begin
         cnt_reg  <= ld_val;
         zero_reg <= (ld_val == '0);
      end else if (dec) begin
         cnt_reg  <= cnt_reg - LW'(1);
         zero_reg <= (cnt_reg == LW'(1));
      end
   end

   assign cnt  = cnt_reg;
   assign zero = zero_reg;

endmodule

// File: rtl/mc_burst_agen.sv
// Burst address generator: one command in, one word address per beat out,
// with linear stepping or power-of-two boundary wrap.
module mc_burst_agen
   import mc_burst_agen_pkg::*;
#(
   parameter int AW = MC_AG_AW,
   parameter int LW = MC_AG_LW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
   input  logic          cmd_wrap,
   output logic          adr_valid,
   input  logic          adr_ready,
   output logic [AW-1:0] adr_out,
   output logic          adr_last,
   output logic          busy
);

   ag_state_t     state_reg, state_next;
   logic [AW-1:0] adr_reg;
   logic [AW-1:0] mask_reg;
   logic [AW-1:0] mask_next;
   logic [LW-1:0] rem;
   logic          rem_zero;
   logic          accept;
   logic          beat;
   logic          len_pow2;

   assign accept = cmd_valid && cmd_ready;
   assign beat   = adr_valid && adr_ready;

   // Beat count is a power of two when (len+1) & len == 0; len = all ones
   // overflows to 0 in LW bits, which correctly marks the 2^LW burst.
   assign len_pow2  = ((cmd_len + LW'(1)) & cmd_len) == '0;
   assign mask_next = (cmd_wrap && len_pow2) ? AW'(cmd_len) : '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= MC_AG_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         MC_AG_IDLE:  if (accept) state_next = MC_AG_BURST;
         MC_AG_BURST: if (beat && rem_zero) state_next = MC_AG_IDLE;
         default:     state_next = MC_AG_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      case (state_reg)
         MC_AG_IDLE:  cmd_ready = !rst;
         MC_AG_BURST: busy      = 1'b1;
         default:     ;
      endcase
   end

   assign adr_valid = busy;
   assign adr_last  = busy && rem_zero;
   assign adr_out   = adr_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         adr_reg  <= '0;
         mask_reg <= '0;
      end else if (accept) begin
         adr_reg  <= cmd_addr;
         mask_reg <= mask_next;
      end else if (beat && !rem_zero) begin
         adr_reg  <= (adr_reg & ~mask_reg) | ((adr_reg + AW'(1)) & mask_reg);
      end
   end

   mc_burst_cnt #(
      .LW(LW)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .ld     (accept),
      .ld_val (cmd_len),
      .dec    (beat && (rem != '0)),
      .cnt    (rem),
      .zero   (rem_zero)
   );

endmodule
